// File: rtl/fsm_job_driver_pkg.sv
// Shared definitions for the example_fsm job driver: engine one-hot bit indices,
// driver state encodings and a one-hot test helper.
package fsm_job_driver_pkg;

  localparam int STATE_W      = 5;
  localparam int ST_IDLE      = 0;
  localparam int ST_PIPE1     = 1;
  localparam int ST_PIPE2     = 2;
  localparam int ST_LOAD_NEXT = 3;
  localparam int ST_LOAD_DOUT = 4;

  typedef enum logic [2:0] {
    D_IDLE  = 3'd0,
    D_START = 3'd1,
    D_ACK   = 3'd2,
    D_RUN   = 3'd3,
    D_DONE  = 3'd4
  } drv_state_t;

  function automatic logic is_onehot(input logic [STATE_W-1:0] s);
    return (s != '0) && ((s & (s - {{(STATE_W-1){1'b0}}, 1'b1})) == '0);
  endfunction

endpackage

// File: rtl/fsm_watchdog.sv
// Start-ack watchdog: counts enabled cycles, hit is high on the TMO_MAX-th consecutive one.
// Clear wins over enable; the count parks at the hit value until cleared.
module fsm_watchdog #(
  parameter int TMO_W   = 6,
  parameter int TMO_MAX = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_MAX - 1);

  logic [TMO_W-1:0] cnt;

  assign hit = en && (cnt == LAST);

  always_ff @(posedge clock) begin
    if (!reset || clr) begin
      cnt <= '0;
    end else if (en && !hit) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

endmodule

// File: rtl/fsm_job_driver.sv
// Job initiator for example_fsm: starts the engine, counts passes, raises done for the last pass.
// Optional one-hot state checking (err_onehot port) is built when FSM_ONEHOT_CHECK_EN is defined.
module fsm_job_driver
  import fsm_job_driver_pkg::*;
#(
  parameter int ITER_W  = 8,
  parameter int TMO_W   = 6,
  parameter int TMO_MAX = 40
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [ITER_W-1:0]  job_iters,
  output logic               din_rdy,
  output logic               done,
  input  logic [STATE_W-1:0] state,
  output logic               job_done,
  output logic [ITER_W-1:0]  job_passes,
  output logic               err_tmo
`ifdef FSM_ONEHOT_CHECK_EN
  ,
  output logic               err_onehot
`endif
);

  drv_state_t        fsm;
  logic [ITER_W-1:0] target;
  logic [ITER_W-1:0] pass;
  logic              wd_en;
  logic              wd_clr;
  logic              wd_hit;
  logic              abort;
  logic              last_pass;

  // The engine's IDLE bit carries no information the driver acts on.
  logic unused_state_idle;
  assign unused_state_idle = state[ST_IDLE];

  assign wd_en     = (fsm == D_ACK);
  assign wd_clr    = (fsm != D_ACK);
  assign last_pass = (pass == target - ITER_W'(1));

`ifdef FSM_ONEHOT_CHECK_EN
  logic bad_state;
  assign bad_state = !is_onehot(state);
  assign abort     = bad_state;
`else
  assign abort     = 1'b0;
`endif

  fsm_watchdog #(
    .TMO_W   (TMO_W),
    .TMO_MAX (TMO_MAX)
  ) u_watchdog (
    .clock (clock),
    .reset (reset),
    .clr   (wd_clr),
    .en    (wd_en),
    .hit   (wd_hit)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      fsm        <= D_IDLE;
      job_ready  <= 1'b1;
      din_rdy    <= 1'b0;
      done       <= 1'b0;
      job_done   <= 1'b0;
      job_passes <= '0;
      err_tmo    <= 1'b0;
      target     <= '0;
      pass       <= '0;
`ifdef FSM_ONEHOT_CHECK_EN
      err_onehot <= 1'b0;
`endif
    end else begin
`ifdef FSM_ONEHOT_CHECK_EN
      if (bad_state) begin
        err_onehot <= 1'b1;
      end
`endif
      case (fsm)
        D_IDLE: begin
          if (job_valid) begin
            target    <= (job_iters == '0) ? ITER_W'(1) : job_iters;
            pass      <= '0;
            job_ready <= 1'b0;
            din_rdy   <= 1'b1;
            fsm       <= D_START;
          end
        end

        D_START: begin
          din_rdy <= 1'b0;
          fsm     <= D_ACK;
        end

        // Engine acknowledgement beats a simultaneous watchdog hit.
        D_ACK: begin
          if (abort) begin
            job_ready <= 1'b1;
            fsm       <= D_IDLE;
          end else if (state[ST_PIPE1]) begin
            fsm <= D_RUN;
          end else if (wd_hit) begin
            err_tmo   <= 1'b1;
            job_ready <= 1'b1;
            fsm       <= D_IDLE;
          end
        end

        D_RUN: begin
          if (abort) begin
            done      <= 1'b0;
            job_ready <= 1'b1;
            fsm       <= D_IDLE;
          end else begin
            if (state[ST_LOAD_NEXT] && (pass != '1)) begin
              pass <= pass + ITER_W'(1);
            end
            // LOAD_DOUT may arrive early; the short count is reported as-is.
            if (state[ST_LOAD_DOUT]) begin
              done       <= 1'b0;
              job_done   <= 1'b1;
              job_passes <= pass;
              fsm        <= D_DONE;
            end else begin
              done <= state[ST_PIPE2] && last_pass;
            end
          end
        end

        D_DONE: begin
          job_done  <= 1'b0;
          job_ready <= 1'b1;
          fsm       <= D_IDLE;
        end

        default: begin
          din_rdy   <= 1'b0;
          done      <= 1'b0;
          job_done  <= 1'b0;
          job_ready <= 1'b1;
          fsm       <= D_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_job_driver.sv
// Directed bench for fsm_job_driver against a small behavioural example_fsm engine.
module tb_fsm_job_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       job_valid = 1'b0;
  logic [7:0] job_iters = 8'd0;
  logic       job_ready;
  logic       din_rdy;
  logic       done;
  logic       job_done;
  logic [7:0] job_passes;
  logic       err_tmo;
`ifdef FSM_ONEHOT_CHECK_EN
  logic       err_onehot;
`endif

  logic [4:0] eng_state;
  logic [4:0] force_val = 5'b00001;
  logic       force_en = 1'b0;
  logic       eng_hold = 1'b0;
  logic       early_out = 1'b0;
  logic       ignore_done = 1'b0;
  logic [4:0] state_bus;

  int         checks = 0;
  int         errors = 0;

  logic [4:0] seq_q[$];
  logic       done_q[$];
  int         n_din;
  int         ln_cnt;
  int         ln_limit = 0;
  logic       got_done;
  logic [7:0] got_passes;

  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_P1   = 5'b00010;
  localparam logic [4:0] S_P2   = 5'b00100;
  localparam logic [4:0] S_LN   = 5'b01000;
  localparam logic [4:0] S_LD   = 5'b10000;

  assign state_bus = force_en ? force_val : eng_state;

  always #5 clk = ~clk;

  // Engine model: IDLE -start-> PIPE1 -> PIPE2 -> LOAD_NEXT -(done)-> LOAD_DOUT -> IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eng_state <= S_IDLE;
    end else begin
      case (eng_state)
        S_IDLE:  if (din_rdy && !eng_hold) eng_state <= S_P1;
        S_P1:    eng_state <= S_P2;
        S_P2:    eng_state <= S_LN;
        S_LN:    eng_state <= ((done && !ignore_done) || early_out) ? S_LD : S_P1;
        default: eng_state <= S_IDLE;
      endcase
    end
  end

  fsm_job_driver #(
    .ITER_W  (8),
    .TMO_W   (6),
    .TMO_MAX (40)
  ) dut (
    .clock      (clk),
    .reset      (rst_n),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_iters  (job_iters),
    .din_rdy    (din_rdy),
    .done       (done),
    .state      (state_bus),
    .job_done   (job_done),
    .job_passes (job_passes),
    .err_tmo    (err_tmo)
`ifdef FSM_ONEHOT_CHECK_EN
    ,
    .err_onehot (err_onehot)
`endif
  );

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Submits one job and records the engine trace until job_done or the cycle budget runs out.
  task automatic run_job(input logic [7:0] iters);
    seq_q.delete();
    done_q.delete();
    n_din = 0;
    ln_cnt = 0;
    got_done = 1'b0;
    got_passes = 8'd0;
    @(negedge clk);
    job_valid = 1'b1;
    job_iters = iters;
    @(negedge clk);
    job_valid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (din_rdy) n_din++;
      if (state_bus != S_IDLE) begin
        seq_q.push_back(state_bus);
        done_q.push_back(done);
      end
      if (state_bus == S_LN) begin
        ln_cnt++;
        if (ln_limit != 0 && ln_cnt == ln_limit) early_out = 1'b1;
      end
      if (job_done) begin
        got_done = 1'b1;
        got_passes = job_passes;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({job_ready, din_rdy, done, job_done, err_tmo} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_outputs: got rdy/din/done/jd/tmo=%b want 10000",
               {job_ready, din_rdy, done, job_done, err_tmo});
    end
    checks++;
    if (job_passes !== 8'd0) begin
      errors++;
      $display("FAIL reset_passes: got %0d want 0", job_passes);
    end
    checks++;
    if (state_bus !== S_IDLE) begin
      errors++;
      $display("FAIL reset_engine_state: got %b want 00001", state_bus);
    end
`ifdef FSM_ONEHOT_CHECK_EN
    checks++;
    if (err_onehot !== 1'b0) begin
      errors++;
      $display("FAIL reset_err_onehot: got %b want 0", err_onehot);
    end
`endif
  endtask

  task automatic test_two_pass();
    logic [4:0] exp_seq [7];
    logic [6:0] dm;
    logic       seq_bad;
    exp_seq = '{S_P1, S_P2, S_LN, S_P1, S_P2, S_LN, S_LD};
    run_job(8'd2);
    checks++;
    if (got_done !== 1'b1 || got_passes !== 8'd2) begin
      errors++;
      $display("FAIL two_pass_result: got done=%b passes=%0d want done=1 passes=2", got_done, got_passes);
    end
    checks++;
    if (n_din != 1) begin
      errors++;
      $display("FAIL two_pass_din_rdy_pulses: got %0d want 1", n_din);
    end
    seq_bad = (seq_q.size() != 7);
    dm = 7'd0;
    for (int i = 0; i < 7 && i < seq_q.size(); i++) begin
      if (seq_q[i] !== exp_seq[i]) seq_bad = 1'b1;
      dm[i] = done_q[i];
    end
    checks++;
    if (seq_bad) begin
      errors++;
      $display("FAIL two_pass_state_seq: got %0d states, first %b want P1,P2,LN,P1,P2,LN,LD",
               seq_q.size(), (seq_q.size() > 0) ? seq_q[0] : 5'b0);
    end
    checks++;
    if (dm !== 7'b0100000) begin
      errors++;
      $display("FAIL two_pass_done_window: got %b want 0100000", dm);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (job_passes !== 8'd2 || job_done !== 1'b0) begin
      errors++;
      $display("FAIL two_pass_hold: got passes=%0d job_done=%b want 2,0", job_passes, job_done);
    end
  endtask

  task automatic test_min_iters();
    logic [7:0] iters_tab [2];
    logic [3:0] dm;
    iters_tab = '{8'd0, 8'd1};
    for (int k = 0; k < 2; k++) begin
      run_job(iters_tab[k]);
      checks++;
      if (got_done !== 1'b1 || got_passes !== 8'd1 || seq_q.size() != 4) begin
        errors++;
        $display("FAIL min_iters_%0d: got done=%b passes=%0d states=%0d want 1,1,4",
                 iters_tab[k], got_done, got_passes, seq_q.size());
      end
      dm = 4'd0;
      for (int i = 0; i < 4 && i < done_q.size(); i++) dm[i] = done_q[i];
      checks++;
      if (dm !== 4'b0100) begin
        errors++;
        $display("FAIL min_iters_%0d_done_window: got %b want 0100", iters_tab[k], dm);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   n;
    logic got;
    n = 0;
    got = 1'b0;
    @(negedge clk);
    job_valid = 1'b1;
    job_iters = 8'd1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (din_rdy) n++;
      if (job_done) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (got !== 1'b1 || n != 1) begin
      errors++;
      $display("FAIL b2b_first_job: got done=%b din_rdy_pulses=%0d want 1,1", got, n);
    end
    @(negedge clk);
    checks++;
    if (job_ready !== 1'b1 || din_rdy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_cycle: got rdy=%b din=%b want 1,0", job_ready, din_rdy);
    end
    @(negedge clk);
    job_valid = 1'b0;
    checks++;
    if (din_rdy !== 1'b1 || job_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_accept: got din=%b rdy=%b want 1,0", din_rdy, job_ready);
    end
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (job_done) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (got !== 1'b1 || job_passes !== 8'd1) begin
      errors++;
      $display("FAIL b2b_second_job: got done=%b passes=%0d want 1,1", got, job_passes);
    end
  endtask

  task automatic test_short_count();
    early_out = 1'b1;
    run_job(8'd4);
    early_out = 1'b0;
    checks++;
    if (got_done !== 1'b1 || got_passes !== 8'd1) begin
      errors++;
      $display("FAIL short_count: got done=%b passes=%0d want 1,1", got_done, got_passes);
    end
  endtask

  task automatic test_saturate();
    ignore_done = 1'b1;
    ln_limit = 260;
    run_job(8'd2);
    ignore_done = 1'b0;
    ln_limit = 0;
    early_out = 1'b0;
    checks++;
    if (got_done !== 1'b1 || got_passes !== 8'hFF || ln_cnt != 260) begin
      errors++;
      $display("FAIL saturate: got done=%b passes=%0d ln=%0d want 1,255,260", got_done, got_passes, ln_cnt);
    end
  endtask

  task automatic test_timeout();
    logic seen_jd;
    seen_jd = 1'b0;
    eng_hold = 1'b1;
    @(negedge clk);
    job_valid = 1'b1;
    job_iters = 8'd3;
    @(negedge clk);
    job_valid = 1'b0;
    checks++;
    if (din_rdy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_start: got din_rdy=%b want 1", din_rdy);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (job_done) seen_jd = 1'b1;
    end
    checks++;
    if (err_tmo !== 1'b0 || job_ready !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: got err_tmo=%b rdy=%b want 0,0", err_tmo, job_ready);
    end
    @(negedge clk);
    if (job_done) seen_jd = 1'b1;
    checks++;
    if (err_tmo !== 1'b1 || job_ready !== 1'b1 || seen_jd !== 1'b0) begin
      errors++;
      $display("FAIL tmo_fire: got err_tmo=%b rdy=%b job_done_seen=%b want 1,1,0", err_tmo, job_ready, seen_jd);
    end
    eng_hold = 1'b0;
    run_job(8'd1);
    checks++;
    if (got_done !== 1'b1 || got_passes !== 8'd1 || err_tmo !== 1'b1) begin
      errors++;
      $display("FAIL tmo_next_job: got done=%b passes=%0d err_tmo=%b want 1,1,1", got_done, got_passes, err_tmo);
    end
  endtask

  task automatic test_reset_mid_job();
    int ln;
    ln = 0;
    @(negedge clk);
    job_valid = 1'b1;
    job_iters = 8'd5;
    @(negedge clk);
    job_valid = 1'b0;
    for (int c = 0; c < 200 && ln < 3; c++) begin
      @(negedge clk);
      if (state_bus == S_LN) ln++;
    end
    checks++;
    if (ln != 3) begin
      errors++;
      $display("FAIL mid_reset_reach_ln3: got %0d LOAD_NEXT want 3", ln);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({din_rdy, done, job_ready, job_done, err_tmo} !== 5'b00100 || job_passes !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got din/done/rdy/jd/tmo=%b passes=%0d want 00100,0",
               {din_rdy, done, job_ready, job_done, err_tmo}, job_passes);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_job(8'd3);
    checks++;
    if (got_done !== 1'b1 || got_passes !== 8'd3) begin
      errors++;
      $display("FAIL post_reset_job: got done=%b passes=%0d want 1,3", got_done, got_passes);
    end
  endtask

`ifdef FSM_ONEHOT_CHECK_EN
  task automatic test_onehot();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    job_valid = 1'b1;
    job_iters = 8'd3;
    @(negedge clk);
    job_valid = 1'b0;
    for (int c = 0; c < 50 && state_bus != S_P2; c++) @(negedge clk);
    checks++;
    if (state_bus !== S_P2 || err_onehot !== 1'b0) begin
      errors++;
      $display("FAIL onehot_setup: got state=%b err_onehot=%b want 00100,0", state_bus, err_onehot);
    end
    force_val = 5'b00110;
    force_en = 1'b1;
    @(negedge clk);
    force_en = 1'b0;
    checks++;
    if (err_onehot !== 1'b1 || job_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL onehot_abort: got err=%b rdy=%b done=%b want 1,1,0", err_onehot, job_ready, done);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (job_done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || err_onehot !== 1'b1) begin
      errors++;
      $display("FAIL onehot_no_job_done: got job_done_seen=%b err=%b want 0,1", seen, err_onehot);
    end
    apply_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_two_pass();
    test_min_iters();
    test_back_to_back();
    test_short_count();
    test_saturate();
    test_timeout();
    test_reset_mid_job();
`ifdef FSM_ONEHOT_CHECK_EN
    test_onehot();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
